// File: rtl/sw_pio_event_ctrl.sv
// Purpose : Avalon-MM master for a switch PIO. It writes the IRQ mask after reset. On each
//           IRQ it reads and clears edge_capture, reads the levels and queues {edges, levels}.
// Latency : pio_irq seen in IDLE at edge T -> event pushed at edge T+4 (5-cycle service period).
// Backpressure: FWFT FIFO drained with evt_valid/evt_ready. A push into a full FIFO with no pop
//           in the same cycle is dropped and counted in overflow_cnt, which saturates at 255.
// Ports   : clk, reset_n (async, active-low), enable (gates new service sequences);
//           pio_address/chipselect/write_n/writedata/readdata/irq - Avalon-MM master to the PIO;
//           evt_valid/evt_ready/evt_edges/evt_level - event stream; overflow_cnt - dropped events.
module sw_pio_event_ctrl #(
    parameter int               WIDTH         = 10,
    parameter int               FIFO_DEPTH    = 4,
    parameter logic [WIDTH-1:0] IRQ_MASK_INIT = '1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    output logic [1:0]       pio_address,
    output logic             pio_chipselect,
    output logic             pio_write_n,
    output logic [31:0]      pio_writedata,
    input  logic [31:0]      pio_readdata,
    input  logic             pio_irq,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [WIDTH-1:0] evt_edges,
    output logic [WIDTH-1:0] evt_level,
    output logic [7:0]       overflow_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    localparam logic [1:0]  OFS_DATA  = 2'd0;
    localparam logic [1:0]  OFS_MASK  = 2'd2;
    localparam logic [1:0]  OFS_EDGE  = 2'd3;
    localparam logic [31:0] MASK_WORD = 32'(IRQ_MASK_INIT);

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_RD_EDGE, S_CLR, S_RD_LVL, S_PUSH
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0] edges;
        logic [WIDTH-1:0] level;
    } evt_t;

    state_t           state_q;
    logic             cs_q;
    logic             wr_n_q;
    logic [1:0]       addr_q;
    logic [31:0]      wdata_q;
    logic [WIDTH-1:0] edge_q;

    // Bus outputs are loaded with the values of the state being entered, so they line up with
    // state_q and never depend combinationally on pio_readdata or pio_irq. The mask write is
    // launched on the INIT->IDLE edge. It is therefore on the bus in the first IDLE cycle, and
    // the registered outputs keep their idle reset values while state is INIT.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_INIT;
            cs_q    <= 1'b0;
            wr_n_q  <= 1'b1;
            addr_q  <= OFS_DATA;
            wdata_q <= '0;
            edge_q  <= '0;
        end else begin
            case (state_q)
                S_INIT: begin
                    state_q <= S_IDLE;
                    cs_q    <= 1'b1;
                    wr_n_q  <= 1'b0;
                    addr_q  <= OFS_MASK;
                    wdata_q <= MASK_WORD;
                end
                S_IDLE: begin
                    wr_n_q  <= 1'b1;
                    wdata_q <= '0;
                    if (pio_irq && enable) begin
                        state_q <= S_RD_EDGE;
                        cs_q    <= 1'b1;
                        addr_q  <= OFS_EDGE;
                    end else begin
                        cs_q    <= 1'b0;
                        addr_q  <= OFS_DATA;
                    end
                end
                S_RD_EDGE: begin
                    // Any write to edge_capture clears every captured bit.
                    state_q <= S_CLR;
                    cs_q    <= 1'b1;
                    wr_n_q  <= 1'b0;
                    addr_q  <= OFS_EDGE;
                    wdata_q <= '1;
                end
                S_CLR: begin
                    // The PIO registers readdata, so the edge_capture read issued in
                    // RD_EDGE is valid during this cycle.
                    edge_q  <= pio_readdata[WIDTH-1:0];
                    state_q <= S_RD_LVL;
                    cs_q    <= 1'b1;
                    wr_n_q  <= 1'b1;
                    addr_q  <= OFS_DATA;
                    wdata_q <= '0;
                end
                S_RD_LVL: begin
                    state_q <= S_PUSH;
                    cs_q    <= 1'b0;
                    wr_n_q  <= 1'b1;
                    addr_q  <= OFS_DATA;
                    wdata_q <= '0;
                end
                default: begin
                    // PUSH, plus recovery from any unused encoding.
                    state_q <= S_IDLE;
                    cs_q    <= 1'b0;
                    wr_n_q  <= 1'b1;
                    addr_q  <= OFS_DATA;
                    wdata_q <= '0;
                end
            endcase
        end
    end

    assign pio_chipselect = cs_q;
    assign pio_write_n    = wr_n_q;
    assign pio_address    = addr_q;
    assign pio_writedata  = wdata_q;

    // Event FIFO. The pointers carry one extra wrap bit so that full and empty are distinct.
    evt_t          mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]    ovf_q, ovf_d;
    logic          empty, full, pop, push_req, push_ok, drop;
    evt_t          push_dat;

    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop      = !empty && evt_ready;
        // A capture value of zero is a spurious interrupt. It is neither queued nor counted.
        push_req = (state_q == S_PUSH) && (edge_q != '0);
        // A full FIFO still accepts the push when the head leaves in the same cycle.
        push_ok  = push_req && (!full || pop);
        drop     = push_req && full && !pop;
        push_dat.edges = edge_q;
        push_dat.level = pio_readdata[WIDTH-1:0];
        wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        ovf_d    = (drop && ovf_q != 8'hFF) ? ovf_q + 8'd1 : ovf_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            if (push_ok) begin
                mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
            end
        end
    end

    assign evt_valid    = !empty;
    assign evt_edges    = mem_q[rd_ptr_q[AW-1:0]].edges;
    assign evt_level    = mem_q[rd_ptr_q[AW-1:0]].level;
    assign overflow_cnt = ovf_q;

    // The PIO data bits above WIDTH are never looked at.
    if (WIDTH < 32) begin : g_rdata_hi
        logic unused_rdata_hi;
        assign unused_rdata_hi = ^pio_readdata[31:WIDTH];
    end

endmodule

// File: tb/tb_sw_pio_event_ctrl.sv
// Purpose : Self-checking bench for sw_pio_event_ctrl with a behavioural switch PIO model.
// Latency : expected events are queued at stimulus time and popped by a handshake monitor.
// Backpressure: evt_ready is driven per phase (random, held low, single-cycle pulse).
`timescale 1ns/1ps
module tb_sw_pio_event_ctrl;

    localparam int W     = 10;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [W-1:0] edges;
        logic [W-1:0] level;
    } evt_t;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         enable;
    logic [1:0]   pio_address;
    logic         pio_chipselect;
    logic         pio_write_n;
    logic [31:0]  pio_writedata;
    logic [31:0]  pio_readdata;
    logic         pio_irq;
    logic         evt_valid;
    logic         evt_ready;
    logic [W-1:0] evt_edges;
    logic [W-1:0] evt_level;
    logic [7:0]   overflow_cnt;

    always #5 clk = ~clk;

    sw_pio_event_ctrl #(
        .WIDTH         (W),
        .FIFO_DEPTH    (DEPTH),
        .IRQ_MASK_INIT (10'h3FF)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .enable         (enable),
        .pio_address    (pio_address),
        .pio_chipselect (pio_chipselect),
        .pio_write_n    (pio_write_n),
        .pio_writedata  (pio_writedata),
        .pio_readdata   (pio_readdata),
        .pio_irq        (pio_irq),
        .evt_valid      (evt_valid),
        .evt_ready      (evt_ready),
        .evt_edges      (evt_edges),
        .evt_level      (evt_level),
        .overflow_cnt   (overflow_cnt)
    );

    // Switch PIO model: synchronised input, any-edge capture, mask, registered readdata.
    logic [W-1:0] in_port;
    logic [W-1:0] sync_q, prev_q, cap_q, mask_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q       <= '0;
            prev_q       <= '0;
            cap_q        <= '0;
            mask_q       <= '0;
            pio_readdata <= '0;
        end else begin
            sync_q <= in_port;
            prev_q <= sync_q;
            if (pio_chipselect && !pio_write_n && pio_address == 2'd3) cap_q <= '0;
            else cap_q <= cap_q | (sync_q ^ prev_q);
            if (pio_chipselect && !pio_write_n && pio_address == 2'd2) mask_q <= pio_writedata[W-1:0];
            case (pio_address)
                2'd0:    pio_readdata <= {22'd0, sync_q};
                2'd2:    pio_readdata <= {22'd0, mask_q};
                2'd3:    pio_readdata <= {22'd0, cap_q};
                default: pio_readdata <= '0;
            endcase
        end
    end
    assign pio_irq = |(cap_q & mask_q);

    // Scoreboard state and counters.
    evt_t         exp_q[$];
    int           exp_occ = 0;
    int           exp_ovf = 0;
    int           n_checks = 0;
    int           n_fail = 0;
    int           bus_cycles = 0;
    int           init_writes = 0;
    int           pops = 0;
    int           rcnt = 0;
    bit           rand_mode = 1'b0;
    logic [W-1:0] cur = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: bus activity counters and the event pop comparison.
    always @(negedge clk) begin
        if (reset_n) begin
            if (pio_chipselect) bus_cycles++;
            if (pio_chipselect && !pio_write_n && pio_address == 2'd2 && pio_writedata == 32'h3FF)
                init_writes++;
            if (evt_valid && evt_ready) begin
                evt_t e;
                pops++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL evt_pop_unexpected: got edges=0x%0h level=0x%0h expected no event",
                             evt_edges, evt_level);
                end else begin
                    e = exp_q.pop_front();
                    exp_occ--;
                    if (evt_edges !== e.edges || evt_level !== e.level) begin
                        n_fail++;
                        $display("FAIL evt_pop: got edges=0x%0h level=0x%0h expected edges=0x%0h level=0x%0h",
                                 evt_edges, evt_level, e.edges, e.level);
                    end
                end
            end
        end
    end

    // Random consumer: ready at least once every four cycles so the FIFO never fills here.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_mode) begin
                rcnt++;
                evt_ready = ($urandom_range(0, 1) == 1) || (rcnt % 4 == 0);
            end
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    // Change the switches. Expected event: edges = old ^ new, level = new. It is dropped when
    // the model FIFO is full, unless the caller guarantees a pop in the push cycle.
    task automatic toggle(input logic [W-1:0] nv, input bit force_acc);
        evt_t e;
        @(posedge clk);
        #1;
        e.edges = cur ^ nv;
        e.level = nv;
        if (exp_occ < DEPTH || force_acc) begin
            exp_q.push_back(e);
            exp_occ++;
        end else if (exp_ovf < 255) begin
            exp_ovf++;
        end
        in_port = nv;
        cur     = nv;
    endtask

    // Returns on the negedge where pio_irq is first high; the DUT samples it at the next posedge.
    task automatic wait_irq();
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (pio_irq) seen = 1'b1;
        end
        check("irq_seen", 32'(seen), 32'd1);
    endtask

    task automatic drain(input string name);
        evt_ready = 1'b1;
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        check({name, "_valid_low"}, 32'(evt_valid), 32'd0);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_cs"},     32'(pio_chipselect), 32'd0);
        check({name, "_wr_n"},   32'(pio_write_n),    32'd1);
        check({name, "_addr"},   32'(pio_address),    32'd0);
        check({name, "_wdata"},  pio_writedata,       32'd0);
        check({name, "_valid"},  32'(evt_valid),      32'd0);
        check({name, "_edges"},  32'(evt_edges),      32'd0);
        check({name, "_level"},  32'(evt_level),      32'd0);
        check({name, "_ovf"},    32'(overflow_cnt),   32'd0);
    endtask

    initial begin
        int pb;
        int bc;
        int iw;
        logic [W-1:0] nv;

        reset_n   = 1'b0;
        enable    = 1'b1;
        evt_ready = 1'b1;
        in_port   = '0;

        // Reset values, then INIT mask write.
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        reset_n = 1'b1;
        idle(4);
        #1;
        check("init_write_count", 32'(init_writes), 32'd1);
        check("mask_readback", 32'(mask_q), 32'h3FF);

        // Single event on bit 3 with exact evt_valid timing.
        toggle(10'h008, 1'b0);
        wait_irq();
        @(posedge clk);               // edge T: IDLE sees pio_irq
        repeat (3) @(posedge clk);
        #1;
        check("valid_low_before_T4", 32'(evt_valid), 32'd0);
        @(posedge clk);
        #1;
        check("valid_high_at_T4", 32'(evt_valid), 32'd1);
        idle(4);
        #1;
        check("edge_capture_cleared", 32'(cap_q), 32'd0);
        drain("single");

        // Multi-bit toggle, then toggle one bit back.
        toggle(10'h000, 1'b0);
        idle(12);
        toggle(10'h201, 1'b0);
        idle(12);
        toggle(10'h200, 1'b0);
        idle(12);
        drain("multi");

        // Random switch patterns against random consumer backpressure.
        rand_mode = 1'b1;
        for (int k = 0; k < 20; k++) begin
            nv = W'($urandom_range(0, 1023));
            if (nv == cur) nv = ~cur;
            toggle(nv, 1'b0);
            idle(12 + $urandom_range(0, 5));
        end
        rand_mode = 1'b0;
        drain("rand");

        // Overflow: six events into a depth-4 FIFO with no consumer.
        evt_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            toggle(cur ^ (10'h001 << k), 1'b0);
            idle(12);
        end
        #1;
        check("ovf_after_six", 32'(overflow_cnt), 32'd2);
        check("ovf_full_valid", 32'(evt_valid), 32'd1);
        pb = pops;
        drain("ovf");
        check("ovf_drain_pops", 32'(pops - pb), 32'd4);

        // Full FIFO with push and pop in the same cycle.
        evt_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            toggle(cur ^ (10'h010 << k), 1'b0);
            idle(12);
        end
        toggle(cur ^ 10'h100, 1'b1);
        wait_irq();
        @(posedge clk);               // edge T
        repeat (3) @(posedge clk);
        #1;
        evt_ready = 1'b1;             // PUSH cycle
        @(posedge clk);
        #1;
        evt_ready = 1'b0;
        idle(2);
        #1;
        check("sim_ovf_unchanged", 32'(overflow_cnt), 32'(exp_ovf));
        check("sim_still_valid", 32'(evt_valid), 32'd1);
        pb = pops;
        drain("sim");
        check("sim_drain_pops", 32'(pops - pb), 32'd4);

        // enable=0 holds off the service; pio_irq stays high with no bus cycles.
        enable = 1'b0;
        bc = bus_cycles;
        toggle(cur ^ 10'h004, 1'b0);
        idle(12);
        #1;
        check("en_irq_pending", 32'(pio_irq), 32'd1);
        check("en_no_bus_cycles", 32'(bus_cycles - bc), 32'd0);
        check("en_no_event", 32'(evt_valid), 32'd0);
        enable = 1'b1;
        idle(12);
        drain("en");

        // Overflow counter saturation.
        evt_ready = 1'b0;
        for (int k = 0; k < 260; k++) begin
            toggle(cur ^ 10'h002, 1'b0);
            idle(10);
        end
        #1;
        check("ovf_saturated", 32'(overflow_cnt), 32'd255);
        drain("sat");

        // Reset asserted during CLR.
        toggle(cur ^ 10'h040, 1'b0);
        wait_irq();
        @(posedge clk);               // edge T: RD_EDGE follows
        @(posedge clk);
        #1;
        check("clr_bus_write", {28'd0, pio_chipselect, pio_write_n, pio_address}, {28'd0, 1'b1, 1'b0, 2'd3});
        check("clr_wdata", pio_writedata, 32'hFFFF_FFFF);
        reset_n = 1'b0;
        in_port = '0;
        cur     = '0;
        #1;
        check_reset_outputs("midrst");
        exp_q.delete();
        exp_occ = 0;
        exp_ovf = 0;
        iw = init_writes;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle(4);
        #1;
        check("reinit_write", 32'(init_writes - iw), 32'd1);
        check("reinit_mask", 32'(mask_q), 32'h3FF);
        evt_ready = 1'b1;
        idle(20);
        #1;
        check("no_stale_event", 32'(evt_valid), 32'd0);
        check("reinit_ovf", 32'(overflow_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
